mda_char_gen: RTL and testbench

- Pixel generator directly downstream of the MDA position counter. Consumes col/row/char_row/char_pixel/add_one/enable.
- Prefetches the next character cell from video RAM and its glyph row from font ROM, then decodes MDA attributes, cursor and blink.
- Produces registered monochrome video/intensity bits for the sync/output stage.

---
 rtl/mda_pkg.sv | 42 ++++
 rtl/mda_attr_decode.sv | 45 ++++
 rtl/mda_char_gen.sv | 188 ++++++++++++++++++
 tb/tb_mda_char_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mda_pkg.sv
// Shared constants and helpers for the MDA character/pixel generator.
package mda_pkg;

   localparam int COLS      = 80;
   localparam int ROWS      = 25;
   localparam int CHAR_ROWS = 14;
   localparam int CELLS     = 2000;

   // Position limits and fetch pipeline pixel slots
   localparam logic [6:0] LAST_COL    = 7'd79;
   localparam logic [4:0] LAST_ROW    = 5'd24;
   localparam logic [3:0] LAST_SCAN   = 4'd13;
   localparam logic [3:0] FETCH_PIXEL = 4'd5;
   localparam logic [3:0] LATCH_PIXEL = 4'd6;
   localparam logic [3:0] GLYPH_PIXEL = 4'd7;
   localparam logic [3:0] LAST_PIXEL  = 4'd8;
   localparam logic [3:0] UL_ROW      = 4'd12;

   // Frame counter taps
   localparam int CHAR_BLINK_BIT = 4;
   localparam int CUR_BLINK_BIT  = 3;

   // Attribute byte layout
   localparam int         ATTR_BLINK  = 7;
   localparam int         ATTR_INTENS = 3;
   localparam logic [7:0] INVIS_MASK  = 8'h77;

   // Box-drawing range that replicates glyph bit 0 into the ninth pixel
   localparam logic [7:0] BOX_FIRST = 8'hC0;
   localparam logic [7:0] BOX_LAST  = 8'hDF;

   typedef struct packed {
      logic [7:0] attr;
      logic [7:0] code;
   } cell_t;

   // Linear cell index of a text position
   function automatic logic [10:0] cell_index(input logic [4:0] r, input logic [6:0] c);
      return (11'(r) * 11'd80) + 11'(c);
   endfunction

endpackage

// File: rtl/mda_attr_decode.sv
// Combinational MDA attribute, blink and cursor decode for one pixel.
module mda_attr_decode
   import mda_pkg::*;
(
   input  logic       glyph_bit,
   input  logic [7:0] attr,
   input  logic [3:0] char_row,
   input  logic       blink_on,
   input  logic       cursor_hit,
   output logic       video,
   output logic       intensity
);

   logic invisible_s;
   logic reverse_s;
   logic underline_s;
   logic blink_off_s;
   logic fg_s;

   // Resolve the pixel: cursor overrides everything, then invisible, reverse, normal
   always_comb begin
      invisible_s = ((attr & INVIS_MASK) == 8'h00);
      reverse_s   = (attr[6:4] == 3'b111) && (attr[2:0] == 3'b000);
      underline_s = (attr[2:0] == 3'b001) && (char_row == UL_ROW);
      blink_off_s = attr[ATTR_BLINK] & ~blink_on;
      fg_s        = (glyph_bit | underline_s) & ~blink_off_s;
      video       = 1'b0;
      intensity   = 1'b0;
      if (cursor_hit) begin
         video     = 1'b1;
         intensity = attr[ATTR_INTENS];
      end else if (invisible_s) begin
         video     = 1'b0;
         intensity = 1'b0;
      end else if (reverse_s) begin
         // lit pixels are background here, so never intense
         video     = ~fg_s;
         intensity = 1'b0;
      end else begin
         video     = fg_s;
         intensity = fg_s & attr[ATTR_INTENS];
      end
   end

endmodule

// File: rtl/mda_char_gen.sv
// MDA pixel generator: prefetches the next cell and glyph row during
// pixels 5-8 of the current cell, then renders registered video/intensity.
module mda_char_gen
   import mda_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        add_one,
   input  logic [6:0]  col,
   input  logic [4:0]  row,
   input  logic [3:0]  char_row,
   input  logic [3:0]  char_pixel,
   output logic [10:0] vram_addr,
   output logic        vram_rd,
   input  logic [15:0] vram_data,
   output logic [11:0] font_addr,
   output logic        font_rd,
   input  logic [7:0]  font_data,
   input  logic [10:0] cursor_pos,
   input  logic        cursor_en,
   input  logic [3:0]  cursor_start,
   input  logic [3:0]  cursor_end,
   output logic        video,
   output logic        intensity
);

   logic [10:0] here_idx_s;
   logic [10:0] next_idx_s;
   logic [3:0]  next_scan_s;
   logic        glyph_bit_s;
   logic        cursor_hit_s;
   logic        video_s;
   logic        intensity_s;
   logic        is_box_s;

   // Valid chain: a cell renders only if its full VRAM->font fetch completed
   logic        vram_pend_r;
   logic        font_pend_r;
   logic        next_valid_r;
   logic        cur_valid_r;

   cell_t       next_cell_r;
   logic [7:0]  next_glyph_r;
   logic [10:0] next_idx_r;
   cell_t       cur_cell_r;
   logic [7:0]  cur_glyph_r;
   logic [10:0] cur_idx_r;
   logic [4:0]  frame_cnt_r;

   // Next-cell index and scanline, including end-of-row and end-of-frame wraps
   always_comb begin
      here_idx_s  = cell_index(row, col);
      next_idx_s  = 11'd0;
      next_scan_s = char_row;
      if (col != LAST_COL) begin
         next_idx_s  = here_idx_s + 11'd1;
         next_scan_s = char_row;
      end else if (char_row != LAST_SCAN) begin
         next_idx_s  = cell_index(row, 7'd0);
         next_scan_s = char_row + 4'd1;
      end else begin
         next_scan_s = 4'd0;
         if (row != LAST_ROW) begin
            next_idx_s = cell_index(row + 5'd1, 7'd0);
         end else begin
            next_idx_s = 11'd0;
         end
      end
   end

   // Memory strobes/addresses; the RAMs register them so data lands one pixel later
   always_comb begin
      vram_rd   = 1'b0;
      font_rd   = 1'b0;
      vram_addr = 11'd0;
      font_addr = 12'd0;
      if (rst) begin
         vram_rd   = enable & (char_pixel == FETCH_PIXEL);
         font_rd   = enable & (char_pixel == LATCH_PIXEL);
         vram_addr = add_one ? next_idx_s : here_idx_s;
         font_addr = {vram_data[7:0], next_scan_s};
      end else begin
         vram_rd   = 1'b0;
         font_rd   = 1'b0;
         vram_addr = 11'd0;
         font_addr = 12'd0;
      end
   end

   // Prefetch pipeline and cur<=next handover at the last pixel of a cell
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vram_pend_r  <= 1'b0;
         font_pend_r  <= 1'b0;
         next_valid_r <= 1'b0;
         cur_valid_r  <= 1'b0;
         next_cell_r  <= '0;
         next_glyph_r <= 8'h00;
         next_idx_r   <= 11'd0;
         cur_cell_r   <= '0;
         cur_glyph_r  <= 8'h00;
         cur_idx_r    <= 11'd0;
      end else if (enable) begin
         case (char_pixel)
            FETCH_PIXEL: vram_pend_r <= 1'b1;
            LATCH_PIXEL: begin
               font_pend_r <= vram_pend_r;
               vram_pend_r <= 1'b0;
               if (vram_pend_r) begin
                  next_cell_r <= vram_data;
               end
            end
            GLYPH_PIXEL: begin
               next_valid_r <= font_pend_r;
               font_pend_r  <= 1'b0;
               if (font_pend_r) begin
                  next_glyph_r <= font_data;
                  next_idx_r   <= next_idx_s;
               end
            end
            LAST_PIXEL: begin
               cur_cell_r   <= next_cell_r;
               cur_glyph_r  <= next_glyph_r;
               cur_idx_r    <= next_idx_r;
               cur_valid_r  <= next_valid_r;
               next_valid_r <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Frame counter steps on the last pixel of the last cell of a frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt_r <= 5'd0;
      end else if (enable && (char_pixel == LAST_PIXEL) && (col == LAST_COL) &&
                   (char_row == LAST_SCAN) && (row == LAST_ROW)) begin
         frame_cnt_r <= frame_cnt_r + 5'd1;
      end
   end

   // Glyph bit for the current pixel; pixel 8 extends box-drawing characters
   always_comb begin
      is_box_s    = (cur_cell_r.code >= BOX_FIRST) && (cur_cell_r.code <= BOX_LAST);
      glyph_bit_s = 1'b0;
      if (char_pixel <= 4'd7) begin
         glyph_bit_s = cur_glyph_r[3'd7 - char_pixel[2:0]];
      end else if ((char_pixel == LAST_PIXEL) && is_box_s) begin
         glyph_bit_s = cur_glyph_r[0];
      end else begin
         glyph_bit_s = 1'b0;
      end
   end

   // Cursor hit; an inverted start/end window never matches
   always_comb begin
      cursor_hit_s = cur_valid_r && cursor_en && (cur_idx_r == cursor_pos) &&
                     (cursor_start <= char_row) && (char_row <= cursor_end) &&
                     frame_cnt_r[CUR_BLINK_BIT];
   end

   mda_attr_decode u_attr_decode (
      .glyph_bit  (glyph_bit_s),
      .attr       (cur_cell_r.attr),
      .char_row   (char_row),
      .blink_on   (frame_cnt_r[CHAR_BLINK_BIT]),
      .cursor_hit (cursor_hit_s),
      .video      (video_s),
      .intensity  (intensity_s)
   );

   // Registered pixel outputs, blanked when idle or before the first full prefetch
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         video     <= 1'b0;
         intensity <= 1'b0;
      end else if (enable) begin
         video     <= video_s & cur_valid_r;
         intensity <= intensity_s & cur_valid_r;
      end else begin
         video     <= 1'b0;
         intensity <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mda_char_gen.sv
// Directed bench for mda_char_gen with behavioural VRAM/font ROM.
module tb_mda_char_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        add_one;
   logic [6:0]  col;
   logic [4:0]  row;
   logic [3:0]  char_row;
   logic [3:0]  char_pixel;
   logic [10:0] vram_addr;
   logic        vram_rd;
   logic [15:0] vram_data;
   logic [11:0] font_addr;
   logic        font_rd;
   logic [7:0]  font_data;
   logic [10:0] cursor_pos;
   logic        cursor_en;
   logic [3:0]  cursor_start;
   logic [3:0]  cursor_end;
   logic        video;
   logic        intensity;

   logic [15:0] vram [0:2047];
   logic [7:0]  font [0:4095];

   int errors = 0;
   int checks = 0;

   logic [10:0] s_vram_addr;
   logic        s_vram_rd;
   logic [11:0] s_font_addr;
   logic        s_font_rd;
   logic        s_video;
   logic        s_int;
   logic [8:0]  v;
   logic [8:0]  vi;

   mda_char_gen dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .add_one      (add_one),
      .col          (col),
      .row          (row),
      .char_row     (char_row),
      .char_pixel   (char_pixel),
      .vram_addr    (vram_addr),
      .vram_rd      (vram_rd),
      .vram_data    (vram_data),
      .font_addr    (font_addr),
      .font_rd      (font_rd),
      .font_data    (font_data),
      .cursor_pos   (cursor_pos),
      .cursor_en    (cursor_en),
      .cursor_start (cursor_start),
      .cursor_end   (cursor_end),
      .video        (video),
      .intensity    (intensity)
   );

   always #5 clk = ~clk;

   // Synchronous memories: data follows the strobe by one clock
   always @(posedge clk) begin
      if (vram_rd) vram_data <= vram[vram_addr];
      if (font_rd) font_data <= font[font_addr];
   end

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One enable cycle: comb outputs sampled mid-cycle, registered ones after the edge
   task automatic step(input logic [6:0] c, input logic [4:0] r, input logic [3:0] cr, input logic [3:0] cp);
      col = c; row = r; char_row = cr; char_pixel = cp;
      add_one = (cp >= 4'd5); enable = 1'b1;
      #2;
      s_vram_addr = vram_addr; s_vram_rd = vram_rd;
      s_font_addr = font_addr; s_font_rd = font_rd;
      @(posedge clk); #1;
      s_video = video; s_int = intensity;
      @(negedge clk);
   endtask

   // Prefetch from the previous cell, then render cell (c,r); p0 is the MSB
   task automatic show(input logic [6:0] c, input logic [4:0] r, input logic [3:0] cr,
                       output logic [8:0] ov, output logic [8:0] oi);
      for (int p = 5; p <= 8; p++) step(c - 7'd1, r, cr, 4'(p));
      for (int p = 0; p <= 8; p++) begin
         step(c, r, cr, 4'(p));
         ov[8-p] = s_video;
         oi[8-p] = s_int;
      end
   endtask

   task automatic frame_tick(input int n);
      for (int k = 0; k < n; k++) step(7'd79, 5'd24, 4'd13, 4'd8);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) vram[i] = 16'h0000;
      for (int i = 0; i < 4096; i++) font[i] = 8'h00;
      vram[0]  = 16'h07AB;
      vram[1]  = 16'h0741;  font[{8'h41, 4'd0}] = 8'h3C;
      vram[2]  = 16'h0FC4;  font[{8'hC4, 4'd1}] = 8'h01;  font[{8'hC4, 4'd0}] = 8'hFF;
      vram[3]  = 16'h0F41;  font[{8'h41, 4'd1}] = 8'h01;
      vram[4]  = 16'h0100;
      vram[5]  = 16'h0700;
      vram[6]  = 16'h7000;
      vram[7]  = 16'h00DB;  font[{8'hDB, 4'd0}] = 8'hFF;
      vram[8]  = 16'h8741;
      vram_data = 16'h0000; font_data = 8'h00;
      rst = 1'b0; enable = 1'b0; add_one = 1'b0;
      col = 7'd0; row = 5'd0; char_row = 4'd0; char_pixel = 4'd0;
      cursor_pos = 11'd0; cursor_en = 1'b0; cursor_start = 4'd0; cursor_end = 4'd0;
      @(negedge clk); @(negedge clk);
      check_eq("rst_video", 16'(video), 16'h0);
      check_eq("rst_int", 16'(intensity), 16'h0);
      check_eq("rst_vram_rd", 16'(vram_rd), 16'h0);
      check_eq("rst_font_rd", 16'(font_rd), 16'h0);
      check_eq("rst_vram_addr", 16'(vram_addr), 16'h0);
      check_eq("rst_font_addr", 16'(font_addr), 16'h0);
      rst = 1'b1;
      @(negedge clk);

      // Basic glyph rendering
      show(7'd1, 5'd0, 4'd0, v, vi);
      check_eq("cell1_video", 16'(v), 16'(9'b001111000));
      check_eq("cell1_int", 16'(vi), 16'h0);
      show(7'd2, 5'd0, 4'd1, v, vi);
      check_eq("box_p8_video", 16'(v), 16'(9'b000000011));
      check_eq("box_p8_int", 16'(vi), 16'(9'b000000011));
      show(7'd3, 5'd0, 4'd1, v, vi);
      check_eq("nonbox_p8_video", 16'(v), 16'(9'b000000010));
      check_eq("nonbox_p8_int", 16'(vi), 16'(9'b000000010));

      // Next-cell address generation
      step(7'd79, 5'd2, 4'd3, 4'd5);
      check_eq("addr_wrap_scan", 16'(s_vram_addr), 16'd160);
      check_eq("vram_rd_p5", 16'(s_vram_rd), 16'h1);
      step(7'd79, 5'd2, 4'd3, 4'd6);
      check_eq("font_addr_scan", 16'(s_font_addr), 16'h004);
      check_eq("font_rd_p6", 16'(s_font_rd), 16'h1);
      step(7'd79, 5'd2, 4'd13, 4'd5);
      check_eq("addr_wrap_row", 16'(s_vram_addr), 16'd240);
      step(7'd79, 5'd24, 4'd13, 4'd5);
      check_eq("addr_wrap_frame", 16'(s_vram_addr), 16'd0);
      step(7'd79, 5'd24, 4'd13, 4'd6);
      check_eq("font_addr_frame", 16'(s_font_addr), 16'hAB0);
      step(7'd10, 5'd2, 4'd0, 4'd5);
      check_eq("addr_next_col", 16'(s_vram_addr), 16'd171);
      step(7'd10, 5'd2, 4'd0, 4'd2);
      check_eq("addr_here", 16'(s_vram_addr), 16'd170);
      check_eq("vram_rd_idle", 16'(s_vram_rd), 16'h0);

      // Attribute decode
      show(7'd4, 5'd0, 4'd12, v, vi);
      check_eq("underline_video", 16'(v), 16'h1FF);
      check_eq("underline_int", 16'(vi), 16'h0);
      show(7'd6, 5'd0, 4'd0, v, vi);
      check_eq("reverse_video", 16'(v), 16'h1FF);
      check_eq("reverse_int", 16'(vi), 16'h0);
      show(7'd7, 5'd0, 4'd0, v, vi);
      check_eq("invisible_video", 16'(v), 16'h0);

      // Cursor and blink across frame-counter phases (frame 0, 8, 16)
      cursor_pos = 11'd5; cursor_start = 4'd12; cursor_end = 4'd13; cursor_en = 1'b1;
      show(7'd5, 5'd0, 4'd12, v, vi);
      check_eq("cursor_off_f0", 16'(v), 16'h0);
      frame_tick(8);
      show(7'd5, 5'd0, 4'd12, v, vi);
      check_eq("cursor_on_r12", 16'(v), 16'h1FF);
      check_eq("cursor_on_int", 16'(vi), 16'h0);
      show(7'd5, 5'd0, 4'd13, v, vi);
      check_eq("cursor_on_r13", 16'(v), 16'h1FF);
      show(7'd5, 5'd0, 4'd11, v, vi);
      check_eq("cursor_r11", 16'(v), 16'h0);
      show(7'd8, 5'd0, 4'd0, v, vi);
      check_eq("blink_hidden", 16'(v), 16'h0);
      frame_tick(8);
      show(7'd8, 5'd0, 4'd0, v, vi);
      check_eq("blink_shown", 16'(v), 16'(9'b001111000));
      show(7'd5, 5'd0, 4'd12, v, vi);
      check_eq("cursor_off_f16", 16'(v), 16'h0);
      cursor_en = 1'b0;

      // Reset mid-character at pixel 6 of cell 1
      for (int p = 5; p <= 8; p++) step(7'd0, 5'd0, 4'd0, 4'(p));
      for (int p = 0; p <= 5; p++) step(7'd1, 5'd0, 4'd0, 4'(p));
      col = 7'd1; row = 5'd0; char_row = 4'd0; char_pixel = 4'd6; add_one = 1'b1; enable = 1'b1;
      #2;
      check_eq("pre_rst_video", 16'(video), 16'h1);
      rst = 1'b0;
      #1;
      check_eq("mid_rst_video", 16'(video), 16'h0);
      check_eq("mid_rst_int", 16'(intensity), 16'h0);
      check_eq("mid_rst_vram_rd", 16'(vram_rd), 16'h0);
      check_eq("mid_rst_font_rd", 16'(font_rd), 16'h0);
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      step(7'd1, 5'd0, 4'd0, 4'd7);
      step(7'd1, 5'd0, 4'd0, 4'd8);
      for (int p = 0; p <= 8; p++) begin
         step(7'd2, 5'd0, 4'd0, 4'(p));
         v[8-p] = s_video;
      end
      check_eq("post_rst_blank", 16'(v), 16'h0);
      show(7'd3, 5'd0, 4'd0, v, vi);
      check_eq("post_rst_video", 16'(v), 16'(9'b001111000));
      check_eq("post_rst_int", 16'(vi), 16'(9'b001111000));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
